// File: rtl/axi_lite_sram.sv
// AXI4-Lite slave SRAM model: single-ported word array, programmable response latency, one transaction in flight.
// Optional SRAM_RAND_DELAY_EN adds 0-7 LFSR-driven extra latency cycles per accepted transaction.
module axi_lite_sram #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned       READ_LAT  = 1,
    parameter int unsigned       WRITE_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = 8;
    localparam logic [ADDR_W:0] SPAN = (ADDR_W + 1)'(DEPTH) << 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_RESP,
        S_WR_WAIT,
        S_WR_RESP
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  extra;
    logic [CNT_W-1:0]  rd_load;
    logic [CNT_W-1:0]  wr_load;
    logic [ADDR_W-1:0] off;
    logic [IDX_W-1:0]  idx;
    logic              hit;
    logic              cnt_zero;
    logic              mem_we;

`ifdef SRAM_RAND_DELAY_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, free-running from reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign extra = {{(CNT_W - 3){1'b0}}, lfsr[2:0]};
`else
    assign extra = '0;
`endif

    assign rd_load  = CNT_W'(READ_LAT - 1) + extra;
    assign wr_load  = CNT_W'(WRITE_LAT - 1) + extra;
    assign cnt_zero = (cnt == '0);

    // Decode on the latched address; the low two bits only matter for the range check
    assign off = addr_q - BASE_ADDR;
    assign hit = (addr_q >= BASE_ADDR) && ({1'b0, off} < SPAN);
    assign idx = off[IDX_W+1:2];

    assign mem_we = (state == S_WR_WAIT) && cnt_zero && hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (arvalid) begin
                    state_nxt = S_RD_WAIT;
                end else if (awvalid && wvalid) begin
                    state_nxt = S_WR_WAIT;
                end
            end
            S_RD_WAIT: if (cnt_zero) state_nxt = S_RD_RESP;
            S_RD_RESP: if (rready)   state_nxt = S_IDLE;
            S_WR_WAIT: if (cnt_zero) state_nxt = S_WR_RESP;
            S_WR_RESP: if (bready)   state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    // Valids are pure state decodes so an asynchronous reset drops them immediately
    always_comb begin
        arready = (state == S_IDLE);
        awready = (state == S_IDLE);
        wready  = (state == S_IDLE);
        rvalid  = (state == S_RD_RESP);
        bvalid  = (state == S_WR_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt     <= '0;
            rdata   <= '0;
            rresp   <= '0;
            bresp   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arvalid) begin
                        addr_q <= araddr;
                        cnt    <= rd_load;
                    end else if (awvalid && wvalid) begin
                        addr_q  <= awaddr;
                        wdata_q <= wdata;
                        wstrb_q <= wstrb;
                        cnt     <= wr_load;
                    end
                end
                S_RD_WAIT: begin
                    if (cnt_zero) begin
                        rdata <= hit ? mem[idx] : '0;
                        rresp <= hit ? RESP_OKAY : RESP_DECERR;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WR_WAIT: begin
                    if (cnt_zero) begin
                        bresp <= hit ? RESP_OKAY : RESP_DECERR;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (wstrb_q[i]) begin
                    mem[idx][i*8 +: 8] <= wdata_q[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_sram.sv
// Self-checking bench for axi_lite_sram: directed scenarios followed by randomized traffic against an array model.
module tb_axi_lite_sram;

    localparam int          RL    = 2;
    localparam int          WL    = 4;
    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    axi_lite_sram #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE),
        .READ_LAT(RL), .WRITE_LAT(WL)
    ) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    logic [31:0] model [DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_map(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + DEPTH * 4);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (in_map(a)) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[widx(a)][b*8 +: 8] = d[b*8 +: 8];
            end
        end
    endtask

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        return in_map(a) ? model[widx(a)] : 32'h0;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return in_map(a) ? 2'b00 : 2'b11;
    endfunction

    task automatic wait_rvalid(output int n);
        n = 0;
        while (!rvalid && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic wait_bvalid(output int n);
        n = 0;
        while (!bvalid && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // All bus tasks start and end 1 time unit after a rising edge
    task automatic axi_read(input logic [31:0] a, input int rdly,
                            output logic [31:0] d, output logic [1:0] r, output int lat);
        int k;
        araddr  = a;
        arvalid = 1'b1;
        k = 0;
        while (!arready && k < 64) begin
            @(posedge clk); #1;
            k++;
        end
        check("ar_handshake", arready, 1'b1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_rvalid(lat);
        d = rdata;
        r = rresp;
        repeat (rdly) begin
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int bdly, output logic [1:0] r, output int lat);
        int k;
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        k = 0;
        while (!(awready && wready) && k < 64) begin
            @(posedge clk); #1;
            k++;
        end
        check("aw_handshake", awready, 1'b1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wait_bvalid(lat);
        r = bresp;
        repeat (bdly) begin
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] a;
        logic [31:0] held;
        logic [3:0]  s;
        logic [1:0]  r;
        int          lat;
        int          seen;

        rst = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_rresp", rresp, 2'b00);
        check("rst_bresp", bresp, 2'b00);
        check("rst_arready", arready, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Full write then read back, with latency measurement
        axi_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, r, lat);
        model_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        check("wr_full_bresp", r, 2'b00);
        check("wr_latency", lat, WL);
        axi_read(32'h8000_0010, 0, d, r, lat);
        check("rd_full_data", d, 32'hDEAD_BEEF);
        check("rd_full_rresp", r, 2'b00);
        check("rd_latency", lat, RL);

        // Byte-lane partial write
        axi_write(32'h8000_0010, 32'h0000_5500, 4'b0010, 0, r, lat);
        model_write(32'h8000_0010, 32'h0000_5500, 4'b0010);
        check("wr_part_bresp", r, 2'b00);
        axi_read(32'h8000_0010, 0, d, r, lat);
        check("rd_part_data", d, 32'hDEAD_55EF);

        // Empty strobe is a no-op with OKAY
        axi_write(32'h8000_0012, 32'h1234_5678, 4'h0, 0, r, lat);
        check("wr_nostrb_bresp", r, 2'b00);
        axi_read(32'h8000_0010, 0, d, r, lat);
        check("rd_nostrb_data", d, 32'hDEAD_55EF);

        // Decode boundaries: last mapped word, first unmapped, below base
        axi_write(32'h8000_3FFC, 32'hCAFE_F00D, 4'hF, 0, r, lat);
        model_write(32'h8000_3FFC, 32'hCAFE_F00D, 4'hF);
        axi_write(32'h8000_0000, 32'h0BAD_0BAD, 4'hF, 0, r, lat);
        model_write(32'h8000_0000, 32'h0BAD_0BAD, 4'hF);
        axi_read(32'h8000_4000, 0, d, r, lat);
        check("rd_miss_rresp", r, 2'b11);
        check("rd_miss_rdata", d, 32'h0);
        axi_write(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 0, r, lat);
        check("wr_miss_bresp", r, 2'b11);
        axi_read(32'h8000_3FFC, 0, d, r, lat);
        check("rd_last_word", d, 32'hCAFE_F00D);
        check("rd_last_rresp", r, 2'b00);
        axi_read(32'h8000_0000, 0, d, r, lat);
        check("rd_first_word", d, 32'h0BAD_0BAD);
        axi_read(32'h7FFF_FFFC, 0, d, r, lat);
        check("rd_below_rresp", r, 2'b11);

        // Read and write presented together: read is serviced first
        axi_write(32'h8000_0008, 32'h1111_2222, 4'hF, 0, r, lat);
        model_write(32'h8000_0008, 32'h1111_2222, 4'hF);
        araddr = 32'h8000_0008; arvalid = 1'b1;
        awaddr = 32'h8000_0008; wdata = 32'h3333_4444; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        check("coll_arready", arready, 1'b1);
        check("coll_awready", awready, 1'b1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("coll_awready_busy", awready, 1'b0);
        wait_rvalid(lat);
        check("coll_rvalid", rvalid, 1'b1);
        check("coll_rdata_old", rdata, 32'h1111_2222);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("coll_aw_after_r", awready, 1'b1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(32'h8000_0008, 32'h3333_4444, 4'hF);
        wait_bvalid(lat);
        check("coll_bvalid", bvalid, 1'b1);
        check("coll_bresp", bresp, 2'b00);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        axi_read(32'h8000_0008, 0, d, r, lat);
        check("coll_rd_new", d, 32'h3333_4444);

        // R-channel backpressure: response held stable, no new AR accepted
        araddr = 32'h8000_0010; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_rvalid(lat);
        held = rdata;
        check("bp_rdata", held, 32'hDEAD_55EF);
        for (int i = 0; i < 5; i++) begin
            check("bp_rvalid_hold", rvalid, 1'b1);
            check("bp_rdata_hold", rdata, held);
            check("bp_arready_low", arready, 1'b0);
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("bp_rvalid_drop", rvalid, 1'b0);
        check("bp_arready_back", arready, 1'b1);

        // Reset during write wait phase: write is lost
        awaddr = 32'h8000_0010; wdata = 32'h5A5A_5A5A; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid_bvalid", bvalid, 1'b0);
        check("rst_mid_arready", arready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (bvalid) seen++;
            @(posedge clk); #1;
        end
        check("rst_mid_no_bvalid", seen, 0);
        check("rst_mid_arready_after", arready, 1'b1);
        axi_read(32'h8000_0010, 0, d, r, lat);
        check("rst_mid_word_kept", d, 32'hDEAD_55EF);

        // Randomized traffic over a small preloaded window plus stray misses
        for (int w = 0; w < 16; w++) begin
            a = BASE + 32'(w * 4);
            d = $urandom;
            axi_write(a, d, 4'hF, 0, r, lat);
            model_write(a, d, 4'hF);
        end
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                a = ($urandom_range(0, 1) == 0) ? BASE + DEPTH * 4 + 32'($urandom_range(0, 63) * 4)
                                                : BASE - 32'($urandom_range(1, 64) * 4);
            end else begin
                a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, $urandom_range(0, 3), r, lat);
                check("rnd_bresp", r, exp_resp(a));
                model_write(a, d, s);
            end else begin
                axi_read(a, $urandom_range(0, 3), d, r, lat);
                check("rnd_rdata", d, exp_rdata(a));
                check("rnd_rresp", r, exp_resp(a));
            end
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
